// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the two requester ports and the shared MemoryController port around mem_arbiter.
// Latency: none; this file only groups signals.
// Backpressure: requesters hold their request while reqN_stall=1; completion is the one-cycle reqN_ack.
interface mem_arbiter_if #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_SIZE  = 256
);
    localparam int ADDR_W = $clog2(MEM_SIZE);

    // requester 0
    logic [ADDR_W-1:0]    req0_addr;
    logic                 req0_read_en;
    logic                 req0_write_en;
    logic [MEM_WIDTH-1:0] req0_write_val;
    logic [MEM_WIDTH-1:0] req0_read_val;
    logic                 req0_ack;
    logic                 req0_stall;

    // requester 1
    logic [ADDR_W-1:0]    req1_addr;
    logic                 req1_read_en;
    logic                 req1_write_en;
    logic [MEM_WIDTH-1:0] req1_write_val;
    logic [MEM_WIDTH-1:0] req1_read_val;
    logic                 req1_ack;
    logic                 req1_stall;

    // shared MemoryController port
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_read_en;
    logic                 mem_write_en;
    logic [MEM_WIDTH-1:0] mem_write_val;
    logic [MEM_WIDTH-1:0] mem_read_val;

    // requester favoured on the next contested arbitration
    logic                 token;

    // Arbiter side: serves the requesters and drives the memory port.
    modport slave (
        input  req0_addr, req0_read_en, req0_write_en, req0_write_val,
        output req0_read_val, req0_ack, req0_stall,
        input  req1_addr, req1_read_en, req1_write_en, req1_write_val,
        output req1_read_val, req1_ack, req1_stall,
        output mem_addr, mem_read_en, mem_write_en, mem_write_val,
        input  mem_read_val,
        output token
    );

    // Environment side: the two Cores plus the MemoryController.
    modport master (
        output req0_addr, req0_read_en, req0_write_en, req0_write_val,
        input  req0_read_val, req0_ack, req0_stall,
        output req1_addr, req1_read_en, req1_write_en, req1_write_val,
        input  req1_read_val, req1_ack, req1_stall,
        input  mem_addr, mem_read_en, mem_write_en, mem_write_val,
        output mem_read_val,
        input  token
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter sharing one MemoryController port between two Cores.
// Latency: request seen in IDLE at cycle N, memory access at N+1, ack at N+2; one access every 3 cycles.
// Backpressure: reqN_stall = reqN & ~reqN_ack; the requester holds its request until its ack cycle.
// Optional: define MEM_ARB_BURST_EN to allow up to MAX_BURST back-to-back grants to one requester.
module mem_arbiter #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_SIZE  = 256,
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Burst limit must fit the 4-bit burst counter and allow at least one grant.
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("mem_arbiter: MAX_BURST must be within 1..15");
    end

    state_t               state;
    state_t               state_nxt;
    logic                 grant;
    logic                 grant_nxt;
    logic                 token_r;
    logic                 token_nxt;
    logic                 winner;
    logic                 req0;
    logic                 req1;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [MEM_WIDTH-1:0] rd_val0;
    logic [MEM_WIDTH-1:0] rd_val1;

    assign req0 = bus.req0_read_en | bus.req0_write_en;
    assign req1 = bus.req1_read_en | bus.req1_write_en;

`ifdef MEM_ARB_BURST_EN
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    logic [3:0] burst_cnt;
    logic [3:0] burst_cnt_nxt;
    logic       last_req;
    logic       repeat_grant;

    // A zero count means no grant has been made since reset, so there is no
    // previous owner to extend.
    assign last_req     = grant ? req1 : req0;
    assign repeat_grant = (burst_cnt != 4'd0) && last_req && (burst_cnt < BURST_LIMIT);
`endif

    // Plain round-robin choice: a lone requester wins, a tie goes to the token.
    always_comb begin
        winner = token_r;
        if (req0 && !req1) begin
            winner = 1'b0;
        end else if (!req0 && req1) begin
            winner = 1'b1;
        end
    end

    // Next-state, grant, token and burst-count logic.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        token_nxt = token_r;
`ifdef MEM_ARB_BURST_EN
        burst_cnt_nxt = burst_cnt;
`endif
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = ACCESS;
`ifdef MEM_ARB_BURST_EN
                    if (repeat_grant) begin
                        grant_nxt     = grant;
                        burst_cnt_nxt = burst_cnt + 4'd1;
                    end else begin
                        grant_nxt     = winner;
                        token_nxt     = ~winner;
                        burst_cnt_nxt = 4'd1;
                    end
`else
                    grant_nxt = winner;
                    token_nxt = ~winner;
`endif
                end
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port is driven only during ACCESS; read+write together is a write.
    always_comb begin
        mem_rd            = 1'b0;
        mem_wr            = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_write_val = '0;
        if (state == ACCESS) begin
            if (grant) begin
                mem_wr            = bus.req1_write_en;
                mem_rd            = bus.req1_read_en & ~bus.req1_write_en;
                bus.mem_addr      = bus.req1_addr;
                bus.mem_write_val = bus.req1_write_val;
            end else begin
                mem_wr            = bus.req0_write_en;
                mem_rd            = bus.req0_read_en & ~bus.req0_write_en;
                bus.mem_addr      = bus.req0_addr;
                bus.mem_write_val = bus.req0_write_val;
            end
        end
    end

    // State register; reset abandons any access in flight and re-arbitrates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 1'b0;
            token_r <= 1'b0;
`ifdef MEM_ARB_BURST_EN
            burst_cnt <= 4'd0;
`endif
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            token_r <= token_nxt;
`ifdef MEM_ARB_BURST_EN
            burst_cnt <= burst_cnt_nxt;
`endif
        end
    end

    // Capture read data for the granted requester at the end of its read access.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_val0 <= '0;
            rd_val1 <= '0;
        end else if (state == ACCESS && mem_rd) begin
            if (grant) begin
                rd_val1 <= bus.mem_read_val;
            end else begin
                rd_val0 <= bus.mem_read_val;
            end
        end
    end

    assign bus.mem_read_en   = mem_rd;
    assign bus.mem_write_en  = mem_wr;
    assign bus.req0_read_val = rd_val0;
    assign bus.req1_read_val = rd_val1;
    assign bus.req0_ack      = (state == DONE) && !grant;
    assign bus.req1_ack      = (state == DONE) && grant;
    assign bus.req0_stall    = req0 & ~bus.req0_ack;
    assign bus.req1_stall    = req1 & ~bus.req1_ack;
    assign bus.token         = token_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter with a behavioural MemoryController.
// Latency: checks the request -> access -> ack timing of two cycles.
// Backpressure: checks stall/ack handshakes, contention order and reset mid-access.
module tb_mem_arbiter;
    localparam int MEM_WIDTH = 32;
    localparam int MEM_SIZE  = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [MEM_WIDTH-1:0] mem [MEM_SIZE];
    logic                 pre_en = 1'b0;
    logic [7:0]           pre_addr = 8'd0;
    logic [MEM_WIDTH-1:0] pre_dat = '0;

    mem_arbiter_if #(.MEM_WIDTH(MEM_WIDTH), .MEM_SIZE(MEM_SIZE)) bus ();

    mem_arbiter #(
        .MEM_WIDTH (MEM_WIDTH),
        .MEM_SIZE  (MEM_SIZE),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural MemoryController: combinational read, write at the clock edge.
    assign bus.mem_read_val = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_dat;
        else if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_write_val;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] v);
        bus.req0_read_en = rd; bus.req0_write_en = wr; bus.req0_addr = a; bus.req0_write_val = v;
    endtask

    task automatic set_req1(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] v);
        bus.req1_read_en = rd; bus.req1_write_en = wr; bus.req1_addr = a; bus.req1_write_val = v;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] v);
        pre_en = 1'b1; pre_addr = a; pre_dat = v;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        set_req0(1'b0, 1'b0, 8'd0, 32'd0);
        set_req1(1'b0, 1'b0, 8'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        tests++; if (bus.token !== 1'b0) begin fails++; $display("FAIL reset_token: got %0h want 0", bus.token); end
        tests++; if (bus.mem_read_en !== 1'b0 || bus.mem_write_en !== 1'b0) begin fails++; $display("FAIL reset_mem_en: got rd=%0b wr=%0b want 0/0", bus.mem_read_en, bus.mem_write_en); end
        tests++; if (bus.mem_addr !== 8'd0 || bus.mem_write_val !== 32'd0) begin fails++; $display("FAIL reset_mem_bus: got addr=%0h val=%0h want 0/0", bus.mem_addr, bus.mem_write_val); end
        tests++; if (bus.req0_ack !== 1'b0 || bus.req1_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %0b%0b want 00", bus.req0_ack, bus.req1_ack); end
        tests++; if (bus.req0_read_val !== 32'd0 || bus.req1_read_val !== 32'd0) begin fails++; $display("FAIL reset_read_val: got %0h/%0h want 0/0", bus.req0_read_val, bus.req1_read_val); end
        tests++; if (bus.req0_stall !== 1'b0 || bus.req1_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b%0b want 00", bus.req0_stall, bus.req1_stall); end
    endtask

    task automatic test_single_read;
        preload(8'd5, 32'hA5);
        // cycle 0
        set_req0(1'b1, 1'b0, 8'd5, 32'd0);
        #1;
        tests++; if (bus.req0_stall !== 1'b1 || bus.mem_read_en !== 1'b0) begin fails++; $display("FAIL rd_c0: got stall=%0b rd_en=%0b want 1/0", bus.req0_stall, bus.mem_read_en); end
        // cycle 1
        tick(); #1;
        tests++; if (bus.mem_read_en !== 1'b1 || bus.mem_addr !== 8'd5 || bus.req0_stall !== 1'b1) begin fails++; $display("FAIL rd_c1: got rd_en=%0b addr=%0h stall=%0b want 1/5/1", bus.mem_read_en, bus.mem_addr, bus.req0_stall); end
        // cycle 2
        tick(); #1;
        tests++; if (bus.req0_ack !== 1'b1 || bus.req0_stall !== 1'b0) begin fails++; $display("FAIL rd_ack: got ack=%0b stall=%0b want 1/0", bus.req0_ack, bus.req0_stall); end
        tests++; if (bus.req0_read_val !== 32'hA5) begin fails++; $display("FAIL rd_val: got %0h want a5", bus.req0_read_val); end
        tests++; if (bus.mem_read_en !== 1'b0) begin fails++; $display("FAIL rd_done_en: got %0b want 0", bus.mem_read_en); end
        tick();
        set_req0(1'b0, 1'b0, 8'd0, 32'd0);
        #1;
        tests++; if (bus.token !== 1'b1) begin fails++; $display("FAIL rd_token: got %0b want 1", bus.token); end
    endtask

    task automatic test_contention;
        do_reset();
        set_req0(1'b0, 1'b1, 8'd3, 32'h11);
        set_req1(1'b0, 1'b1, 8'd4, 32'h22);
        #1;
        tests++; if (bus.req0_stall !== 1'b1 || bus.req1_stall !== 1'b1) begin fails++; $display("FAIL ct_c0_stall: got %0b%0b want 11", bus.req0_stall, bus.req1_stall); end
        tick(); #1; // cycle 1
        tests++; if (bus.mem_write_en !== 1'b1 || bus.mem_addr !== 8'd3 || bus.mem_write_val !== 32'h11) begin fails++; $display("FAIL ct_c1_wr0: got wr=%0b addr=%0h val=%0h want 1/3/11", bus.mem_write_en, bus.mem_addr, bus.mem_write_val); end
        tick(); #1; // cycle 2
        tests++; if (bus.req0_ack !== 1'b1 || bus.req1_ack !== 1'b0 || bus.req1_stall !== 1'b1) begin fails++; $display("FAIL ct_c2_ack0: got ack0=%0b ack1=%0b stall1=%0b want 1/0/1", bus.req0_ack, bus.req1_ack, bus.req1_stall); end
        tick(); // cycle 3
        set_req0(1'b0, 1'b0, 8'd0, 32'd0);
        #1;
        tests++; if (bus.mem_write_en !== 1'b0) begin fails++; $display("FAIL ct_c3_idle: got wr=%0b want 0", bus.mem_write_en); end
        tick(); #1; // cycle 4
        tests++; if (bus.mem_write_en !== 1'b1 || bus.mem_addr !== 8'd4 || bus.mem_write_val !== 32'h22) begin fails++; $display("FAIL ct_c4_wr1: got wr=%0b addr=%0h val=%0h want 1/4/22", bus.mem_write_en, bus.mem_addr, bus.mem_write_val); end
        tick(); #1; // cycle 5
        tests++; if (bus.req1_ack !== 1'b1 || bus.req0_ack !== 1'b0) begin fails++; $display("FAIL ct_c5_ack1: got ack1=%0b ack0=%0b want 1/0", bus.req1_ack, bus.req0_ack); end
        tests++; if (bus.token !== 1'b0) begin fails++; $display("FAIL ct_token: got %0b want 0", bus.token); end
        tick();
        set_req1(1'b0, 1'b0, 8'd0, 32'd0);
        #1;
        tests++; if (mem[3] !== 32'h11 || mem[4] !== 32'h22) begin fails++; $display("FAIL ct_mem: got %0h/%0h want 11/22", mem[3], mem[4]); end
    endtask

    task automatic test_fairness;
        bit exp_g [12];
        int done0, done1, w0, w1, g, wmax;
        logic a0, a1, got;
`ifdef MEM_ARB_BURST_EN
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        wmax  = 15;
`else
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        wmax  = 6;
`endif
        do_reset();
        done0 = 0; done1 = 0; w0 = 0; w1 = 0; g = 0;
        set_req0(1'b0, 1'b1, 8'd16, 32'h100);
        set_req1(1'b0, 1'b1, 8'd32, 32'h200);
        for (int cyc = 0; cyc < 150 && (done0 < 6 || done1 < 6); cyc++) begin
            #1;
            a0 = bus.req0_ack;
            a1 = bus.req1_ack;
            if (bus.mem_write_en === 1'b1) begin
                got = (bus.mem_addr >= 8'd32);
                tests++;
                if (g >= 12 || got !== exp_g[g]) begin fails++; $display("FAIL fair_grant%0d: got %0b want %0b", g, got, (g < 12) ? exp_g[g] : 1'bx); end
                g++;
            end
            if (bus.req0_stall === 1'b1) w0++;
            if (bus.req1_stall === 1'b1) w1++;
            if (a0 === 1'b1) begin
                tests++; if (w0 > wmax) begin fails++; $display("FAIL fair_wait0: got %0d cycles want <= %0d", w0, wmax); end
                done0++; w0 = 0;
            end
            if (a1 === 1'b1) begin
                tests++; if (w1 > wmax) begin fails++; $display("FAIL fair_wait1: got %0d cycles want <= %0d", w1, wmax); end
                done1++; w1 = 0;
            end
            tick();
            if (a0 === 1'b1) begin
                if (done0 < 6) set_req0(1'b0, 1'b1, 8'(16 + done0), 32'(256 + done0));
                else set_req0(1'b0, 1'b0, 8'd0, 32'd0);
            end
            if (a1 === 1'b1) begin
                if (done1 < 6) set_req1(1'b0, 1'b1, 8'(32 + done1), 32'(512 + done1));
                else set_req1(1'b0, 1'b0, 8'd0, 32'd0);
            end
        end
        set_req0(1'b0, 1'b0, 8'd0, 32'd0);
        set_req1(1'b0, 1'b0, 8'd0, 32'd0);
        tests++; if (done0 != 6 || done1 != 6 || g != 12) begin fails++; $display("FAIL fair_complete: got acks %0d/%0d grants %0d want 6/6/12", done0, done1, g); end
        tick();
    endtask

    task automatic test_read_write_both;
        int n;
        preload(8'd9, 32'h5A5A);
        preload(8'd7, 32'h77);
        set_req1(1'b1, 1'b0, 8'd9, 32'd0);
        n = 0;
        #1;
        while (bus.req1_ack !== 1'b1 && n < 10) begin tick(); #1; n++; end
        tests++; if (bus.req1_ack !== 1'b1 || bus.req1_read_val !== 32'h5A5A) begin fails++; $display("FAIL rw_pre_read: got ack=%0b val=%0h want 1/5a5a", bus.req1_ack, bus.req1_read_val); end
        tick();
        set_req1(1'b1, 1'b1, 8'd7, 32'h33);
        tick(); #1; // access cycle
        tests++; if (bus.mem_write_en !== 1'b1 || bus.mem_read_en !== 1'b0 || bus.mem_addr !== 8'd7 || bus.mem_write_val !== 32'h33) begin fails++; $display("FAIL rw_access: got wr=%0b rd=%0b addr=%0h val=%0h want 1/0/7/33", bus.mem_write_en, bus.mem_read_en, bus.mem_addr, bus.mem_write_val); end
        tick(); #1; // ack cycle
        tests++; if (bus.req1_ack !== 1'b1 || bus.req1_read_val !== 32'h5A5A) begin fails++; $display("FAIL rw_ack: got ack=%0b read_val=%0h want 1/5a5a", bus.req1_ack, bus.req1_read_val); end
        tick();
        set_req1(1'b0, 1'b0, 8'd0, 32'd0);
        #1;
        tests++; if (mem[7] !== 32'h33) begin fails++; $display("FAIL rw_mem: got %0h want 33", mem[7]); end
    endtask

    task automatic test_reset_mid_access;
        do_reset();
        set_req0(1'b1, 1'b0, 8'd5, 32'd0); // cycle 0
        tick(); #1;                          // cycle 1: ACCESS
        tests++; if (bus.mem_read_en !== 1'b1 || bus.token !== 1'b1) begin fails++; $display("FAIL rm_access: got rd=%0b token=%0b want 1/1", bus.mem_read_en, bus.token); end
        reset = 1'b1;
        tick(); #1;                          // cycle 2: back in IDLE
        tests++; if (bus.req0_ack !== 1'b0 || bus.token !== 1'b0) begin fails++; $display("FAIL rm_after: got ack=%0b token=%0b want 0/0", bus.req0_ack, bus.token); end
        tests++; if (bus.mem_read_en !== 1'b0 || bus.mem_write_en !== 1'b0 || bus.mem_addr !== 8'd0 || bus.req0_read_val !== 32'd0) begin fails++; $display("FAIL rm_outputs: got rd=%0b wr=%0b addr=%0h rv=%0h want 0/0/0/0", bus.mem_read_en, bus.mem_write_en, bus.mem_addr, bus.req0_read_val); end
        tests++; if (bus.req0_stall !== 1'b1) begin fails++; $display("FAIL rm_stall: got %0b want 1", bus.req0_stall); end
        reset = 1'b0;
        tick(); #1;                          // cycle 3: re-served
        tests++; if (bus.mem_read_en !== 1'b1 || bus.req0_ack !== 1'b0) begin fails++; $display("FAIL rm_reaccess: got rd=%0b ack=%0b want 1/0", bus.mem_read_en, bus.req0_ack); end
        tick(); #1;                          // cycle 4: ack
        tests++; if (bus.req0_ack !== 1'b1 || bus.req0_read_val !== 32'hA5) begin fails++; $display("FAIL rm_ack: got ack=%0b val=%0h want 1/a5", bus.req0_ack, bus.req0_read_val); end
        tick();
        set_req0(1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_fairness();
        test_read_write_both();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
